// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the parametrised VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel rate.
package vga_timing_pkg;

  localparam int CW_DEFAULT = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  function automatic int h_total(input int sync, input int bp, input int active, input int fp);
    return axis_total(sync, bp, active, fp);
  endfunction

  function automatic int v_total(input int sync, input int bp, input int active, input int fp);
    return axis_total(sync, bp, active, fp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its sync/active region decode.
// Region order along the axis is sync, back porch, active, front porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_active,
  output logic [CW-1:0] offset
);

  localparam int            TOTAL  = axis_total(SYNC, BP, ACTIVE, FP);
  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_N = CW'(SYNC);
  localparam logic [CW-1:0] ACT_LO = CW'(SYNC + BP);
  localparam logic [CW-1:0] ACT_HI = CW'(SYNC + BP + ACTIVE - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wrap    = step && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    in_sync   = (count_q < SYNC_N);
    in_active = (count_q >= ACT_LO) && (count_q <= ACT_HI);
    offset    = in_active ? (count_q - ACT_LO) : '0;
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: registered sync, display-enable, coordinates and strobes.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FCW      = 8
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           vidon,
  output logic [CW-1:0]  hc,
  output logic [CW-1:0]  vc,
  output logic [CW-1:0]  px,
  output logic [CW-1:0]  py,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  logic [CW-1:0] h_count, v_count, h_offset, v_offset;
  logic          h_wrap, v_wrap, h_in_sync, v_in_sync, h_in_active, v_in_active;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)
  ) u_h_axis (
    .clk(clk), .clr_n(clr_n), .step(pix_en),
    .count(h_count), .wrap(h_wrap), .in_sync(h_in_sync),
    .in_active(h_in_active), .offset(h_offset)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)
  ) u_v_axis (
    .clk(clk), .clr_n(clr_n), .step(h_wrap),
    .count(v_count), .wrap(v_wrap), .in_sync(v_in_sync),
    .in_active(v_in_active), .offset(v_offset)
  );

  // top_q marks that the counters hold the first pixel of a frame (after reset or a frame wrap).
  logic top_q, top_d;
  logic hsync_q, vsync_q, vidon_q, line_start_q, frame_start_q;
  logic hsync_d, vsync_d, vidon_d, line_start_d, frame_start_d;
  logic [CW-1:0] hc_q, vc_q, px_q, py_q, px_d, py_d;

  always_comb begin
    top_d = top_q;
    if (v_wrap) begin
      top_d = 1'b1;
    end else if (pix_en) begin
      top_d = 1'b0;
    end
    hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
    vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
    vidon_d       = h_in_active && v_in_active;
    px_d          = vidon_d ? h_offset : '0;
    py_d          = vidon_d ? v_offset : '0;
    line_start_d  = pix_en && (h_count == '0);
    frame_start_d = pix_en && top_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      top_q         <= 1'b1;
      hc_q          <= '0;
      vc_q          <= '0;
      px_q          <= '0;
      py_q          <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      vidon_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      top_q         <= top_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (pix_en) begin
        hc_q    <= h_count;
        vc_q    <= v_count;
        px_q    <= px_d;
        py_q    <= py_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        vidon_q <= vidon_d;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The first frame after reset is still in progress, so it does not count as completed.
  logic           started_q, started_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    started_d   = started_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      started_d = 1'b1;
      if (started_q) begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      started_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      started_q   <= started_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vidon       = vidon_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign px          = px_q;
  assign py          = py_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing with a short vertical mode.
module tb_vga_timing_gen;

  localparam int CW       = 11;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 11;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FCW = 2;
`else
  localparam int FCW = 8;
`endif

  logic           clk;
  logic           clr_n;
  logic           pix_en;
  logic           hsync, vsync, vidon, line_start, frame_start;
  logic [CW-1:0]  hc, vc, px, py;
  logic [FCW-1:0] frame_cnt;

  int checks;
  int failures;

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FCW(FCW)
  ) dut (
    .clk(clk), .clr_n(clr_n), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .vidon(vidon),
    .hc(hc), .vc(vc), .px(px), .py(py),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FCW-1:0] exp_fcnt(input int completed);
`ifdef VGA_TIMING_FRAME_CNT_EN
    return FCW'(completed);
`else
    return (completed > 1000000) ? FCW'(1) : '0;
`endif
  endfunction

  task automatic test_reset();
    logic [4*CW+5+FCW-1:0] got, want;
    clr_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    got  = {hc, vc, px, py, hsync, vsync, vidon, line_start, frame_start, frame_cnt};
    want = {44'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {FCW{1'b0}}};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync_levels got=%b%b want=11", hsync, vsync);
    end
  endtask

  task automatic test_exit_reset();
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hc !== 0 || vc !== 0 || line_start !== 1'b1 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL exit_reset_first got hc=%0d vc=%0d ls=%b fs=%b want 0 0 1 1",
               hc, vc, line_start, frame_start);
    end
    checks++;
    if (hsync !== 1'b0 || vsync !== 1'b0 || vidon !== 1'b0) begin
      failures++;
      $display("FAIL exit_reset_levels got hs=%b vs=%b vid=%b want 0 0 0", hsync, vsync, vidon);
    end
  endtask

  // Starts on the sample that shows hc=0, vc=0 and walks one whole frame against a reference.
  task automatic test_full_frame();
    int errs, hs_low, vs_low, vid_cnt, ls_cnt, fs_cnt, eh, ev;
    bit first_seen, evid;
    logic [CW-1:0] f_hc, f_vc, f_px, f_py, l_hc, l_vc, l_px, l_py, end_hc, end_vc;
    logic [CW-1:0] ehc, evc, epx, epy;
    string first_err;
    errs = 0; hs_low = 0; vs_low = 0; vid_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    first_seen = 1'b0;
    f_hc = '0; f_vc = '0; f_px = '0; f_py = '0;
    l_hc = '0; l_vc = '0; l_px = '0; l_py = '0;
    end_hc = '0; end_vc = '0;
    first_err = "";
    for (int i = 0; i < FRAME; i++) begin
      eh   = i % H_TOTAL;
      ev   = i / H_TOTAL;
      evid = (eh >= 144) && (eh <= 783) && (ev >= 5) && (ev <= 8);
      ehc  = CW'(eh);
      evc  = CW'(ev);
      epx  = evid ? CW'(eh - 144) : '0;
      epy  = evid ? CW'(ev - 5) : '0;
      if (hc !== ehc || vc !== evc || px !== epx || py !== epy || vidon !== evid ||
          hsync !== !(eh < 96) || vsync !== !(ev < 2) || frame_cnt !== exp_fcnt(0)) begin
        if (errs == 0)
          first_err = $sformatf("i=%0d hc=%0d vc=%0d px=%0d py=%0d vid=%b hs=%b vs=%b fc=%0d",
                                i, hc, vc, px, py, vidon, hsync, vsync, frame_cnt);
        errs++;
      end
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (line_start === 1'b1) ls_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (vidon === 1'b1) begin
        vid_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          f_hc = hc; f_vc = vc; f_px = px; f_py = py;
        end
        l_hc = hc; l_vc = vc; l_px = px; l_py = py;
      end
      if (i == FRAME - 1) begin
        end_hc = hc;
        end_vc = vc;
      end
      @(negedge clk);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL frame_trace errors=%0d want=0 first: %s", errs, first_err);
    end
    checks++;
    if (hs_low != 96 * V_TOTAL) begin
      failures++;
      $display("FAIL hsync_low_clks got=%0d want=%0d", hs_low, 96 * V_TOTAL);
    end
    checks++;
    if (vs_low != 2 * H_TOTAL) begin
      failures++;
      $display("FAIL vsync_low_clks got=%0d want=%0d", vs_low, 2 * H_TOTAL);
    end
    checks++;
    if (vid_cnt != H_ACTIVE * V_ACTIVE) begin
      failures++;
      $display("FAIL vidon_clks got=%0d want=%0d", vid_cnt, H_ACTIVE * V_ACTIVE);
    end
    checks++;
    if (ls_cnt != V_TOTAL || fs_cnt != 1) begin
      failures++;
      $display("FAIL strobe_counts got ls=%0d fs=%0d want ls=%0d fs=1", ls_cnt, fs_cnt, V_TOTAL);
    end
    checks++;
    if (f_hc !== 144 || f_vc !== 5 || f_px !== 0 || f_py !== 0) begin
      failures++;
      $display("FAIL first_active got hc=%0d vc=%0d px=%0d py=%0d want 144 5 0 0",
               f_hc, f_vc, f_px, f_py);
    end
    checks++;
    if (l_hc !== 783 || l_vc !== 8 || l_px !== 639 || l_py !== 3) begin
      failures++;
      $display("FAIL last_active got hc=%0d vc=%0d px=%0d py=%0d want 783 8 639 3",
               l_hc, l_vc, l_px, l_py);
    end
    checks++;
    if (end_hc !== 799 || end_vc !== 10) begin
      failures++;
      $display("FAIL frame_last_pixel got hc=%0d vc=%0d want 799 10", end_hc, end_vc);
    end
    checks++;
    if (hc !== 0 || vc !== 0 || frame_start !== 1'b1 || line_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap got hc=%0d vc=%0d fs=%b ls=%b want 0 0 1 1",
               hc, vc, frame_start, line_start);
    end
    checks++;
    if (frame_cnt !== exp_fcnt(1)) begin
      failures++;
      $display("FAIL frame_cnt_1 got=%0d want=%0d", frame_cnt, exp_fcnt(1));
    end
  endtask

  // Starts on a frame_start sample; measures three more frame periods and the counter.
  task automatic test_frame_cnt();
    int n;
    for (int f = 2; f <= 4; f++) begin
      @(negedge clk);
      n = 1;
      while (frame_start !== 1'b1 && n < 2 * FRAME) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != FRAME) begin
        failures++;
        $display("FAIL frame_period_%0d got=%0d want=%0d", f, n, FRAME);
      end
      checks++;
      if (frame_cnt !== exp_fcnt(f)) begin
        failures++;
        $display("FAIL frame_cnt_%0d got=%0d want=%0d", f, frame_cnt, exp_fcnt(f));
      end
    end
  endtask

  task automatic test_pix_en_toggle();
    logic [4*CW+3+FCW-1:0] prev, cur;
    int hold_errs, strobe_errs, ls_first, ls_second;
    hold_errs = 0; strobe_errs = 0; ls_first = -1; ls_second = -1;
    prev = {hc, vc, px, py, hsync, vsync, vidon, frame_cnt};
    for (int c = 0; c < 3400; c++) begin
      pix_en = (c % 2 == 0);
      @(negedge clk);
      cur = {hc, vc, px, py, hsync, vsync, vidon, frame_cnt};
      if (!pix_en) begin
        if (cur !== prev) hold_errs++;
        if (line_start !== 1'b0 || frame_start !== 1'b0) strobe_errs++;
      end
      if (line_start === 1'b1) begin
        if (ls_first < 0) ls_first = c;
        else if (ls_second < 0) ls_second = c;
      end
      prev = cur;
    end
    pix_en = 1'b1;
    checks++;
    if (hold_errs != 0) begin
      failures++;
      $display("FAIL pix_en_hold errors=%0d want=0", hold_errs);
    end
    checks++;
    if (strobe_errs != 0) begin
      failures++;
      $display("FAIL pix_en_strobes errors=%0d want=0", strobe_errs);
    end
    checks++;
    if (ls_first < 0 || ls_second < 0 || (ls_second - ls_first) != 1600) begin
      failures++;
      $display("FAIL half_rate_line_period got first=%0d second=%0d want gap 1600",
               ls_first, ls_second);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [4*CW+5+FCW-1:0] got, want;
    want = {44'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {FCW{1'b0}}};
    n = 0;
    while (!(hc === 400 && vc === 3) && n < FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(hc === 400 && vc === 3)) begin
      failures++;
      $display("FAIL reach_mid_frame got hc=%0d vc=%0d want 400 3", hc, vc);
    end
    clr_n = 1'b0;
    #1;
    got = {hc, vc, px, py, hsync, vsync, vidon, line_start, frame_start, frame_cnt};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset_mid got=%h want=%h", got, want);
    end
    @(negedge clk);
    got = {hc, vc, px, py, hsync, vsync, vidon, line_start, frame_start, frame_cnt};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_hold_mid got=%h want=%h", got, want);
    end
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hc !== 0 || vc !== 0 || frame_start !== 1'b1 || line_start !== 1'b1 || frame_cnt !== 0) begin
      failures++;
      $display("FAIL restart_after_reset got hc=%0d vc=%0d fs=%b ls=%b fc=%0d want 0 0 1 1 0",
               hc, vc, frame_start, line_start, frame_cnt);
    end
    @(negedge clk);
    checks++;
    if (hc !== 1 || vc !== 0 || frame_start !== 1'b0 || line_start !== 1'b0) begin
      failures++;
      $display("FAIL second_pixel_after_reset got hc=%0d vc=%0d fs=%b ls=%b want 1 0 0 0",
               hc, vc, frame_start, line_start);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_n    = 1'b0;
    pix_en   = 1'b0;
    test_reset();
    test_exit_reset();
    test_full_frame();
    test_frame_cnt();
    test_pix_en_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
